mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, cycles from mem_en to valid mem_rdata (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit, single clock; all logic is posedge.
REQ-003 SHALL have port rst, input, 1 bit, reset: synchronous and active-high.
REQ-004 SHALL have ports if_req (input, 1, fetch request) and if_addr (input, 16, fetch address).
REQ-005 SHALL have port if_flush, input, 1 bit, cancels any pending or in-flight fetch (branch/JR/JAL/EXEC redirect).
REQ-006 SHALL have ports if_rdata (output, 16, fetched instruction) and if_valid (output, 1, one-cycle completion pulse).
REQ-007 SHALL have ports d_req (input, 1), d_we (input, 1, 1 = store) and d_addr/d_wdata (inputs, 16 each), for data-stage access.
REQ-008 SHALL have ports d_rdata (output, 16) and d_valid (output, 1, one-cycle completion pulse).
REQ-009 SHALL have ports mem_en, mem_we (outputs, 1 each), mem_addr, mem_wdata (outputs, 16 each) and mem_rdata (input, 16), driving a single-port memory.
REQ-010 SHALL have ports stall_if and stall_d (outputs, 1 each), which feed the PC-hold and pipeline-freeze logic.

Function
REQ-011 SHALL implement FSM states IDLE, ACC_IF, ACC_D.
REQ-012 In IDLE with an eligible request pending, SHALL grant it: capture address/data/we, pulse mem_en for exactly one cycle, and enter ACC_IF or ACC_D.
REQ-013 SHALL count MEM_LAT cycles after mem_en; in the last cycle it SHALL register mem_rdata into the granted side's rdata, pulse that side's valid next cycle, and return to IDLE.
REQ-014 Latency from req rising in IDLE to valid SHALL be MEM_LAT+2 cycles; at most one transaction is outstanding.
REQ-015 A requester SHALL hold req and its operands stable until its valid; the arbiter SHALL NOT re-sample the operands mid-access.
REQ-016 If both requests are eligible in IDLE, the data request SHALL win (fixed priority).
REQ-017 stall_if SHALL equal if_req AND NOT if_valid; stall_d SHALL equal d_req AND NOT d_valid.
REQ-018 For stores, mem_we SHALL be 1 with mem_en; d_valid SHALL pulse at completion; d_rdata SHALL keep its previous value.
REQ-019 if_flush while an ACC_IF access is in flight SHALL let the memory access finish but suppress if_valid and leave if_rdata unchanged.
REQ-020 if_flush in IDLE SHALL block a fetch grant that cycle; a data access SHALL never be cancelled by if_flush.
REQ-021 Addresses SHALL pass through unmodified, full 16 bits, with no wrap logic.

Reset
REQ-022 With rst high at a clock edge, the FSM SHALL enter IDLE and the counter SHALL clear, abandoning any in-flight access without a valid pulse.
REQ-023 Reset values SHALL be: mem_en, mem_we, if_valid, d_valid = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 16'h0000; stall outputs follow REQ-017 with valids at 0.

Configuration
REQ-024 Macro MEM_ARB_FAIR_EN, when defined, SHALL replace REQ-016 with alternating priority: on a tie, the side not granted last wins; the last-grant flag resets to "fetch".
REQ-025 Without MEM_ARB_FAIR_EN, the arbiter SHALL use fixed data priority and contain no last-grant register.

Structure
REQ-026 The FSM state encoding and the MEM_LAT default SHALL live in a shared package, cpu_defs_pkg.
REQ-027 The latency counter SHALL be a sub-module, mem_lat_counter (load, count down, done pulse).

Verification
REQ-028 Single fetch, MEM_LAT=2: if_req at cycle 0, if_addr=16'h0010, memory returns 16'hA5A5 -> mem_en at cycle 1, if_valid with if_rdata=16'hA5A5 at cycle 4; stall_if high for cycles 0-3.
REQ-029 Simultaneous if_req/d_req (load 16'h0200) -> data is granted first; fetch is granted in the cycle after d_valid; with MEM_ARB_FAIR_EN and the last grant = data, a second tie grants fetch.
REQ-030 Store d_we=1, d_addr=16'h0300, d_wdata=16'h1234 -> mem_we=1, mem_addr=16'h0300, mem_wdata=16'h1234 on the mem_en cycle; d_valid pulses; d_rdata is unchanged.
REQ-031 if_flush one cycle after a fetch grant -> no if_valid and if_rdata is unchanged; a new fetch to 16'h0040 is then served normally.
REQ-032 rst asserted during ACC_D -> next cycle the FSM is IDLE, no d_valid, and all outputs are at reset values; a following request completes in MEM_LAT+2 cycles.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg
// Shared definitions for the memory-port arbiter: FSM state encoding,
// the default memory latency, the latency-counter width and the
// fetch/data tie-break helper.
package cpu_defs_pkg;

  // Arbiter FSM states: idle, fetch access in flight, data access in flight.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACC_IF = 2'd1,
    ST_ACC_D  = 2'd2
  } arb_state_e;

  // Cycles from mem_en to valid mem_rdata (legal range 1..15).
  localparam int unsigned MEM_LAT_DEFAULT = 2;

  // Width of the latency down-counter; covers the full 1..15 latency range.
  localparam int unsigned LAT_CNT_W = 4;

  // Returns 1 when the data side should be granted this cycle.
  // prefer_d only matters when both sides are eligible.
  function automatic logic arb_pick_data(input logic if_elig,
                                         input logic d_elig,
                                         input logic prefer_d);
    arb_pick_data = d_elig & (~if_elig | prefer_d);
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// mem_lat_counter
// Memory latency counter: loaded on a grant, counts down once per cycle
// and flags the final cycle of the access (the cycle in which the memory
// read data is valid). Synchronous active-high reset abandons any count.
module mem_lat_counter
  import cpu_defs_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [LAT_CNT_W-1:0] i_load_val,
  output logic                 o_done
);

  logic [LAT_CNT_W-1:0] r_cnt;
  logic                 r_active;
  logic                 w_at_zero;

  assign w_at_zero = (r_cnt == {LAT_CNT_W{1'b0}});

  // Load on grant, then count down each cycle; stop after the zero cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= {LAT_CNT_W{1'b0}};
      r_active <= 1'b0;
    end else if (i_load) begin
      r_cnt    <= i_load_val;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (w_at_zero) begin
        r_active <= 1'b0;
        r_cnt    <= r_cnt;
      end else begin
        r_active <= 1'b1;
        r_cnt    <= r_cnt - {{(LAT_CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      r_cnt    <= r_cnt;
      r_active <= r_active;
    end
  end

  // The access ends in the cycle the counter reaches zero.
  assign o_done = r_active & w_at_zero;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates a single-port memory between the instruction-fetch stage and
// the data stage. One transaction is outstanding at a time; a grant pulses
// mem_en for one cycle, the latency counter times MEM_LAT cycles, and the
// read data is registered into the granted side's rdata with a one-cycle
// valid pulse. Fetches can be cancelled by if_flush; data accesses cannot.
//
// Build option: define MEM_ARB_FAIR_EN for alternating priority on a tie
// (the side not granted last wins, last grant resets to fetch). Without it
// the data side always wins a tie.
module mem_port_arbiter
  import cpu_defs_pkg::*;
#(
  parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        if_flush,
  output logic [15:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_valid,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_d
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LAT);

  arb_state_e  r_state;
  arb_state_e  w_state_nxt;

  logic        w_if_elig;
  logic        w_d_elig;
  logic        w_prefer_d;
  logic        w_grant_if;
  logic        w_grant_d;
  logic        w_lat_done;
  logic        w_if_done_ok;

  logic        r_mem_en;
  logic        r_mem_we;
  logic [15:0] r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic [15:0] r_if_rdata;
  logic        r_if_valid;
  logic [15:0] r_d_rdata;
  logic        r_d_valid;
  logic        r_is_store;
  logic        r_if_kill;

  // A side whose valid is pulsing this cycle has just been served and is
  // not eligible again until the next cycle; a flush blocks a fetch grant.
  assign w_if_elig = if_req & ~r_if_valid & ~if_flush;
  assign w_d_elig  = d_req  & ~r_d_valid;

`ifdef MEM_ARB_FAIR_EN
  logic r_last_d;

  // Remember which side won the latest grant for alternating tie-breaks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_d <= 1'b0;
    end else if (w_grant_d) begin
      r_last_d <= 1'b1;
    end else if (w_grant_if) begin
      r_last_d <= 1'b0;
    end else begin
      r_last_d <= r_last_d;
    end
  end

  assign w_prefer_d = ~r_last_d;
`else
  assign w_prefer_d = 1'b1;
`endif

  // Latency timer for the access in flight.
  mem_lat_counter u_lat_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_grant_if | w_grant_d),
    .i_load_val (LAT_LOAD),
    .o_done     (w_lat_done)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and grant decode.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_if  = 1'b0;
    w_grant_d   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (arb_pick_data(w_if_elig, w_d_elig, w_prefer_d)) begin
          w_grant_d   = 1'b1;
          w_state_nxt = ST_ACC_D;
        end else if (w_if_elig) begin
          w_grant_if  = 1'b1;
          w_state_nxt = ST_ACC_IF;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACC_IF: begin
        if (w_lat_done) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ACC_IF;
        end
      end
      ST_ACC_D: begin
        if (w_lat_done) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ACC_D;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // A fetch completes normally only if no flush was seen at any point
  // during its access, including the final cycle.
  assign w_if_done_ok = (r_state == ST_ACC_IF) & w_lat_done & ~r_if_kill & ~if_flush;

  // Memory command registers: operands are captured only at grant time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 16'h0000;
      r_mem_wdata <= 16'h0000;
      r_is_store  <= 1'b0;
    end else begin
      r_mem_en <= w_grant_if | w_grant_d;
      r_mem_we <= w_grant_d & d_we;
      if (w_grant_d) begin
        r_mem_addr  <= d_addr;
        r_mem_wdata <= d_wdata;
        r_is_store  <= d_we;
      end else if (w_grant_if) begin
        r_mem_addr  <= if_addr;
        r_mem_wdata <= r_mem_wdata;
        r_is_store  <= 1'b0;
      end else begin
        r_mem_addr  <= r_mem_addr;
        r_mem_wdata <= r_mem_wdata;
        r_is_store  <= r_is_store;
      end
    end
  end

  // Sticky fetch-cancel flag for the fetch currently in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_kill <= 1'b0;
    end else if (w_grant_if) begin
      r_if_kill <= 1'b0;
    end else if ((r_state == ST_ACC_IF) && if_flush) begin
      r_if_kill <= 1'b1;
    end else begin
      r_if_kill <= r_if_kill;
    end
  end

  // Completion: register read data into the granted side and pulse valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_rdata <= 16'h0000;
      r_if_valid <= 1'b0;
      r_d_rdata  <= 16'h0000;
      r_d_valid  <= 1'b0;
    end else begin
      r_if_valid <= w_if_done_ok;
      r_d_valid  <= (r_state == ST_ACC_D) & w_lat_done;
      if (w_if_done_ok) begin
        r_if_rdata <= mem_rdata;
      end else begin
        r_if_rdata <= r_if_rdata;
      end
      if ((r_state == ST_ACC_D) && w_lat_done && !r_is_store) begin
        r_d_rdata <= mem_rdata;
      end else begin
        r_d_rdata <= r_d_rdata;
      end
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign if_valid  = r_if_valid;
  assign d_rdata   = r_d_rdata;
  assign d_valid   = r_d_valid;

  // Stalls hold the requesting stage until its completion pulse.
  assign stall_if = if_req & ~r_if_valid;
  assign stall_d  = d_req  & ~r_d_valid;

endmodule
